// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer: prescaled OFF/SOLID/BLINK/CYCLE pattern generator, active-low LEDs.
// Ports: clk, rstn, cfg_we, mode, ch_en, duty (RGB_SEQ_PWM_EN only), tick, led_n.
module rgb_led_sequencer #(
  parameter int CHANNELS     = 3,
  parameter int PRESCALE     = 10000,
  parameter int TICKS_PERIOD = 1000,
  parameter int TICKS_ON     = 250
`ifdef RGB_SEQ_PWM_EN
  ,
  parameter int PWM_W        = 8
`endif
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cfg_we,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] ch_en,
`ifdef RGB_SEQ_PWM_EN
  input  logic [PWM_W-1:0]    duty,
`endif
  output logic                tick,
  output logic [CHANNELS-1:0] led_n
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int HW = (TICKS_PERIOD > 1) ? $clog2(TICKS_PERIOD) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    M_OFF,
    M_SOLID,
    M_BLINK,
    M_CYCLE
  } mode_e;

  logic [PW-1:0]       pre_cnt;
  logic [HW-1:0]       ph_cnt;
  logic [CW-1:0]       ch_idx;
  logic [CW-1:0]       ch_nxt;
  logic [CW-1:0]       cand;
  mode_e               mode_q;
  logic [CHANNELS-1:0] en_q;
  logic [CHANNELS-1:0] lit;
  logic                pre_end;
  logic                ph_end;
  logic                in_on;
  logic                pwm_on;

  assign pre_end = int'(pre_cnt) == PRESCALE - 1;
  assign ph_end  = int'(ph_cnt) == TICKS_PERIOD - 1;
  assign in_on   = int'(ph_cnt) < TICKS_ON;

  // Scan downward so the nearest enabled channel after ch_idx wins;
  // k == CHANNELS is ch_idx itself, so a lone enabled channel stays put.
  always_comb begin
    ch_nxt = ch_idx;
    cand   = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      cand = CW'((int'(ch_idx) + k) % CHANNELS);
      if (en_q[cand]) ch_nxt = cand;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lit
    assign lit[i] = pwm_on & en_q[i] &
      ((mode_q == M_SOLID) |
       (in_on & ((mode_q == M_BLINK) |
                 ((mode_q == M_CYCLE) & (ch_idx == CW'(i))))));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt <= '0;
      ph_cnt  <= '0;
      ch_idx  <= '0;
      mode_q  <= M_OFF;
      en_q    <= '1;
      tick    <= 1'b0;
      led_n   <= '1;
    end else begin
      led_n <= ~lit;
      tick  <= pre_end & ~cfg_we;
      if (cfg_we) begin
        mode_q  <= mode_e'(mode);
        en_q    <= ch_en;
        pre_cnt <= '0;
        ph_cnt  <= '0;
        ch_idx  <= '0;
      end else if (pre_end) begin
        pre_cnt <= '0;
        if (ph_end) begin
          ph_cnt <= '0;
          if (mode_q == M_CYCLE) ch_idx <= ch_nxt;
        end else begin
          ph_cnt <= ph_cnt + 1'b1;
        end
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

`ifdef RGB_SEQ_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_q;

  assign pwm_on = pwm_cnt < duty_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt <= '0;
      duty_q  <= '1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (cfg_we) duty_q <= duty;
    end
  end
`else
  assign pwm_on = 1'b1;
`endif

endmodule
